// File: rtl/mul_float_cal.sv
// mul_float_cal: 3-stage custom-float multiplier producing a signed 32-bit integer (rev 1.0).
// Optional macro MUL_FLOAT_CAL_SATURATE_EN: saturate on overflow or exponent 0xFF.
`default_nettype none

module mul_float_cal (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        inRESET,
  input  logic        iDATA_REQ,
  output logic        oDATA_BUSY,
  input  logic [31:0] iDATA_A,
  input  logic [31:0] iDATA_B,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic [31:0] oDATA
);

  localparam logic [9:0] EXP_BIAS2 = 10'd254;
  localparam logic [9:0] FRAC_POS  = 10'd46;

  logic        advance;
  logic        s1_valid, s1_sign_a, s1_sign_b;
  logic [7:0]  s1_exp_a, s1_exp_b;
  logic [23:0] s1_man_a, s1_man_b;
  logic        s2_valid, s2_sign, s2_zero;
  logic [9:0]  s2_exp;
  logic [47:0] s2_prod;
  logic [63:0] shifted;
  logic [9:0]  rsh_amt, lsh_amt;
  logic [31:0] result;

  assign advance    = !(oDATA_VALID && iDATA_BUSY);
  assign oDATA_BUSY = oDATA_VALID && iDATA_BUSY;
  assign rsh_amt    = FRAC_POS - s2_exp;
  assign lsh_amt    = s2_exp - FRAC_POS;

`ifdef MUL_FLOAT_CAL_SATURATE_EN
  logic s2_inf;
  logic overflow;
  logic unused_pin;
  assign unused_pin = &{1'b0, inRESET};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, inRESET, shifted[63:32]};
`endif

  // Magnitude = floor(P * 2^(e-46)); only the low 32 bits matter once overflow is handled.
  always_comb begin
    shifted = 64'd0;
    if (s2_exp[9]) begin
      shifted = 64'd0;
    end else if (s2_exp <= FRAC_POS) begin
      shifted = {16'd0, s2_prod >> rsh_amt};
    end else if (lsh_amt < 10'd64) begin
      shifted = {16'd0, s2_prod} << lsh_amt[5:0];
    end
  end

`ifdef MUL_FLOAT_CAL_SATURATE_EN
  assign overflow = !s2_exp[9] && ((s2_exp > FRAC_POS) || (|shifted[63:31]));
`endif

  always_comb begin
    result = s2_sign ? (32'd0 - shifted[31:0]) : shifted[31:0];
`ifdef MUL_FLOAT_CAL_SATURATE_EN
    if (overflow || s2_inf) begin
      result = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`endif
    if (s2_zero) begin
      result = 32'd0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      oDATA_VALID <= 1'b0;
      oDATA       <= 32'd0;
    end else if (advance) begin
      s1_valid    <= iDATA_REQ;
      s2_valid    <= s1_valid;
      oDATA_VALID <= s2_valid;
      if (s2_valid) begin
        oDATA <= result;
      end
    end
  end

  // Datapath registers carry no reset; the valid bits qualify them.
  always_ff @(posedge iCLOCK) begin
    if (advance) begin
      if (iDATA_REQ) begin
        s1_exp_a  <= iDATA_A[31:24];
        s1_exp_b  <= iDATA_B[31:24];
        s1_sign_a <= iDATA_A[23];
        s1_sign_b <= iDATA_B[23];
        s1_man_a  <= {1'b1, iDATA_A[22:0]};
        s1_man_b  <= {1'b1, iDATA_B[22:0]};
      end
      s2_prod <= {24'd0, s1_man_a} * {24'd0, s1_man_b};
      s2_exp  <= {2'b00, s1_exp_a} + {2'b00, s1_exp_b} - EXP_BIAS2;
      s2_sign <= s1_sign_a ^ s1_sign_b;
      s2_zero <= (s1_exp_a == 8'd0) || (s1_exp_b == 8'd0);
`ifdef MUL_FLOAT_CAL_SATURATE_EN
      s2_inf  <= (s1_exp_a == 8'hFF) || (s1_exp_b == 8'hFF);
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_float_cal.sv
// tb_mul_float_cal: directed and random checks of mul_float_cal against an arithmetic reference.
`default_nettype none

module tb_mul_float_cal;

  logic        clk = 1'b0;
  logic        rst, req, dbusy;
  logic [31:0] a, b;
  logic        obusy, ovalid;
  logic [31:0] odata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit check_lat = 1'b0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];

`ifdef MUL_FLOAT_CAL_SATURATE_EN
  localparam logic [31:0] BIG_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] BIG_EXP = 32'h0000_0000;
`endif

  mul_float_cal dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .inRESET     (1'b1),
    .iDATA_REQ   (req),
    .oDATA_BUSY  (obusy),
    .iDATA_A     (a),
    .iDATA_B     (b),
    .oDATA_VALID (ovalid),
    .iDATA_BUSY  (dbusy),
    .oDATA       (odata)
  );

  always #5 clk = ~clk;

  // Reference: exact product scaled in a wide integer, then wrapped or saturated.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    logic [47:0] p;
    logic [319:0] big;
    logic        sgn;
    logic [31:0] m;
    ex = int'(x[31:24]);
    ey = int'(y[31:24]);
    if (ex == 0 || ey == 0) return 32'd0;
    e = ex + ey - 254;
    if (e < 0) return 32'd0;
    p   = {24'd1, x[22:0] | 24'h80_0000} * {24'd1, y[22:0] | 24'h80_0000} ;
    p   = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    big = 320'(p);
    big = (big << e) >> 46;
    sgn = x[23] ^ y[23];
`ifdef MUL_FLOAT_CAL_SATURATE_EN
    if (big > 320'h7FFF_FFFF || ex == 255 || ey == 255)
      return sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    m = big[31:0];
    return sgn ? (32'd0 - m) : m;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    logic [7:0]  e;
    int          sel;
    r   = $urandom();
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = r[31:24];
      default: e = 8'($urandom_range(112, 142));
    endcase
    return {e, r[23:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check handshake/data before the edge, check holds/reset after it.
  task automatic step(input logic r, input logic [31:0] xa, input logic [31:0] xb,
                      input logic db, input logic rs, input logic [31:0] expv);
    logic        acc, cons, hold;
    logic [31:0] held;
    int          c0;
    req = r; a = xa; b = xb; dbusy = db; rst = rs;
    #1;
    chk("busy", 32'(obusy), 32'(ovalid & db));
    acc  = r && !obusy && !rs;
    cons = ovalid && !db && !rs;
    hold = ovalid && db && !rs;
    held = odata;
    c0   = cyc;
    if (ovalid && !rs) chk("no_stale", 32'(exp_q.size() > 0), 32'd1);
    if (cons && exp_q.size() > 0) begin
      chk("data", odata, exp_q[0]);
      if (check_lat) chk("latency", 32'(c0 - cyc_q[0]), 32'd3);
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rs) begin
      exp_q.delete();
      cyc_q.delete();
      chk("rst_valid", 32'(ovalid), 32'd0);
      chk("rst_data", odata, 32'd0);
      chk("rst_busy", 32'(obusy), 32'd0);
    end else if (acc) begin
      exp_q.push_back(expv);
      cyc_q.push_back(c0);
    end
    if (hold) begin
      chk("hold_valid", 32'(ovalid), 32'd1);
      chk("hold_data", odata, held);
    end
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    req = 0; a = 0; b = 0; dbusy = 0; rst = 1;
    step(1'b1, 32'h8220_0000, 32'h8220_0000, 1'b0, 1'b1, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);

    // Back-to-back directed products with exact latency.
    check_lat = 1'b1;
    step(1'b1, 32'h8220_0000, 32'h8220_0000, 1'b0, 1'b0, 32'h0000_0064);
    step(1'b1, 32'h8548_0000, 32'h8548_0000, 1'b0, 1'b0, 32'h0000_2710);
    step(1'b1, 32'h887A_0000, 32'h887A_0000, 1'b0, 1'b0, 32'h000F_4240);
    step(1'b1, 32'h8220_0000, 32'h887A_0000, 1'b0, 1'b0, 32'h0000_2710);
    step(1'b1, 32'h82A0_0000, 32'h8220_0000, 1'b0, 1'b0, 32'hFFFF_FF9C);
    step(1'b1, 32'h0000_0000, 32'h887A_0000, 1'b0, 1'b0, 32'h0000_0000);
    step(1'b1, 32'h7E00_0000, 32'h7F00_0000, 1'b0, 1'b0, 32'h0000_0000);
    step(1'b1, 32'h9300_0000, 32'h9300_0000, 1'b0, 1'b0, BIG_EXP);
    drain();

    for (int i = 0; i < 150; i++) begin
      x = rnd_op();
      y = rnd_op();
      step(($urandom_range(0, 3) != 0), x, y, 1'b0, 1'b0, ref_mul(x, y));
    end
    drain();
    check_lat = 1'b0;

    // Downstream stall with queued results, then release.
    step(1'b1, 32'h8220_0000, 32'h8220_0000, 1'b0, 1'b0, 32'h0000_0064);
    step(1'b1, 32'h8548_0000, 32'h8548_0000, 1'b0, 1'b0, 32'h0000_2710);
    step(1'b1, 32'h82A0_0000, 32'h8220_0000, 1'b0, 1'b0, 32'hFFFF_FF9C);
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h887A_0000, 32'h887A_0000, 1'b1, 1'b0, 32'h000F_4240);
    drain();

    for (int i = 0; i < 200; i++) begin
      x = rnd_op();
      y = rnd_op();
      step(($urandom_range(0, 2) != 0), x, y, ($urandom_range(0, 1) == 1), 1'b0, ref_mul(x, y));
    end
    drain();

    // Reset with two operations in flight and a request on the reset edge.
    step(1'b1, 32'h8220_0000, 32'h8220_0000, 1'b0, 1'b0, 32'h0000_0064);
    step(1'b1, 32'h8548_0000, 32'h8548_0000, 1'b0, 1'b0, 32'h0000_2710);
    step(1'b1, 32'h887A_0000, 32'h887A_0000, 1'b0, 1'b1, 32'h000F_4240);
    check_lat = 1'b1;
    step(1'b1, 32'h8220_0000, 32'h887A_0000, 1'b0, 1'b0, 32'h0000_2710);
    for (int i = 0; i < 6; i++) idle();
    chk("post_rst_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
